// File: rtl/operand_fetch.sv
// Operand fetch stage: latches an instruction's register fields, waits until its
// sources and destination are free in the busy scoreboard, captures operands from
// the register file (with writeback forwarding) and holds them until downstream
// accepts. Writeback requests pass straight through to the register file write port.
module operand_fetch #(
    parameter int unsigned N = 5,
    parameter int unsigned B = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    input  logic [N-1:0] rd,
    input  logic         rd_we,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [B-1:0] op1,
    output logic [B-1:0] op2,
    output logic [N-1:0] out_rd,

    input  logic         wb_valid,
    input  logic [N-1:0] wb_addr,
    input  logic [B-1:0] wb_data,

    output logic [N-1:0] rf_r_addr1,
    output logic [N-1:0] rf_r_addr2,
    input  logic [B-1:0] rf_r_data1,
    input  logic [B-1:0] rf_r_data2,

    output logic [N-1:0] rf_w_addr,
    output logic [B-1:0] rf_w_data,
    output logic         rf_write_en
);

    localparam int unsigned NumRegs = 2 ** N;

    typedef enum logic [1:0] {StIdle, StCheck, StOut} state_e;

    state_e              state_q;
    logic [N-1:0]        rs1_q;
    logic [N-1:0]        rs2_q;
    logic [N-1:0]        rd_q;
    logic                rd_we_q;
    logic [NumRegs-1:0]  busy_q;
    logic [NumRegs-1:0]  busy_d;
    logic [NumRegs-1:0]  busy_eff;
    logic [NumRegs-1:0]  clr_vec;
    logic [NumRegs-1:0]  set_vec;
    logic                out_valid_q;
    logic [B-1:0]        op1_q;
    logic [B-1:0]        op2_q;
    logic [N-1:0]        out_rd_q;
    logic                stall;
    logic                leave_check;
    logic [B-1:0]        opnd1;
    logic [B-1:0]        opnd2;
    logic                wb_fwd;

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = out_valid_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign out_rd      = out_rd_q;
    assign rf_r_addr1  = rs1_q;
    assign rf_r_addr2  = rs2_q;

    // Writeback is a pure pass-through; register 0 is never written.
    assign rf_w_addr   = wb_addr;
    assign rf_w_data   = wb_data;
    assign wb_fwd      = wb_valid && (wb_addr != '0);
    assign rf_write_en = wb_fwd;

    // Scoreboard next state: a clear this cycle frees the register for the stall
    // check, and a set from the departing instruction overrides a same-cycle clear.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (wb_valid) begin
            clr_vec[wb_addr] = 1'b1;
        end
        busy_eff    = busy_q & ~clr_vec;
        stall       = busy_eff[rs1_q] | busy_eff[rs2_q] | (rd_we_q & busy_eff[rd_q]);
        leave_check = (state_q == StCheck) && !stall;
        if (leave_check && rd_we_q && (rd_q != '0)) begin
            set_vec[rd_q] = 1'b1;
        end
        busy_d    = busy_eff | set_vec;
        busy_d[0] = 1'b0;
    end

    // Operand selection: x0 reads as zero, otherwise forward a matching writeback.
    always_comb begin
        opnd1 = rf_r_data1;
        opnd2 = rf_r_data2;
        if (rs1_q == '0) begin
            opnd1 = '0;
        end else if (wb_fwd && (wb_addr == rs1_q)) begin
            opnd1 = wb_data;
        end
        if (rs2_q == '0) begin
            opnd2 = '0;
        end else if (wb_fwd && (wb_addr == rs2_q)) begin
            opnd2 = wb_data;
        end
    end

    // Control FSM with registered outputs and scoreboard update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            out_rd_q    <= '0;
        end else begin
            busy_q <= busy_d;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        rs1_q   <= rs1;
                        rs2_q   <= rs2;
                        rd_q    <= rd;
                        rd_we_q <= rd_we;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (!stall) begin
                        op1_q       <= opnd1;
                        op2_q       <= opnd2;
                        out_rd_q    <= rd_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StOut;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule
